// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing fetch/decode/exec/writeback for an 8-bit accumulator CPU
module multicycle_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   instr,
  input  logic         zero,
  output logic         ir_enb,
  output logic         pc_enb,
  output logic [1:0]   pc_sel,
  output logic         acc_enb,
  output logic [2:0]   alu_op,
  output logic         mem_we,
  output logic         busy,
  output logic         halted,
  output logic [2:0]   state,
  output logic [W-1:0] instr_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5} state_t;
  localparam logic [2:0] OP_NOP = 3'd0, OP_LDA = 3'd1, OP_STA = 3'd2, OP_ADD = 3'd3,
                         OP_SUB = 3'd4, OP_JMP = 3'd5, OP_JZ = 3'd6, OP_HLT = 3'd7;
  state_t state_q, nxt;
  logic retire;
  logic [2:0] op, alu;
  assign op = instr[7:5];
  assign alu = op == OP_ADD ? 3'b001 : op == OP_SUB ? 3'b010 : 3'b000;
  assign state = state_q;
  assign busy = state_q != IDLE && state_q != HALT;
  assign halted = state_q == HALT;
  always_comb begin
    nxt = state_q;
    ir_enb = 1'b0;
    pc_enb = 1'b0;
    pc_sel = 2'b00;
    acc_enb = 1'b0;
    alu_op = 3'b000;
    mem_we = 1'b0;
    retire = 1'b0;
    case (state_q)
      IDLE: nxt = start ? FETCH : IDLE;
      FETCH: begin
        ir_enb = 1'b1;
        pc_enb = 1'b1;
        pc_sel = 2'b01;
        nxt = DECODE;
      end
      DECODE: begin
        // zero only matters here, and only for JZ
        pc_enb = op == OP_JMP || (op == OP_JZ && zero);
        pc_sel = pc_enb ? 2'b10 : 2'b00;
        nxt = op == OP_HLT ? HALT
            : (op == OP_LDA || op == OP_STA || op == OP_ADD || op == OP_SUB) ? EXEC : FETCH;
        retire = op == OP_NOP || op == OP_JMP || op == OP_JZ || op == OP_HLT;
      end
      EXEC: begin
        alu_op = alu;
        mem_we = op == OP_STA;
        nxt = op == OP_STA ? FETCH : WB;
        retire = op == OP_STA;
      end
      WB: begin
        alu_op = alu;
        acc_enb = 1'b1;
        nxt = FETCH;
        retire = 1'b1;
      end
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_cnt <= '0;
    end else begin
      state_q <= nxt;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed stimulus with a cycle-tagged scoreboard checked by a separate monitor
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, zero = 1'b0;
  logic [7:0] instr = 8'h00;
  logic ir_enb, pc_enb, acc_enb, mem_we, busy, halted;
  logic [1:0] pc_sel;
  logic [2:0] alu_op, state;
  logic [7:0] instr_cnt;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {int cyc; logic [21:0] v; string tag;} rec_t;
  rec_t q[$];
  rec_t r;
  logic [21:0] act;

  multicycle_ctrl #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .zero(zero),
    .ir_enb(ir_enb), .pc_enb(pc_enb), .pc_sel(pc_sel), .acc_enb(acc_enb),
    .alu_op(alu_op), .mem_we(mem_we), .busy(busy), .halted(halted),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {state, ir_enb, pc_enb, pc_sel, acc_enb, alu_op, mem_we, busy, halted, instr_cnt};

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      r = q.pop_front();
      n_chk++;
      if (r.cyc != cyc || act !== r.v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got=%h want=%h", r.tag, cyc, act, r.v);
      end
    end
  end

  function automatic logic [21:0] ev(input logic [2:0] st, input logic ir, input logic pe,
                                     input logic [1:0] ps, input logic ae, input logic [2:0] op,
                                     input logic we, input logic [7:0] cnt);
    return {st, ir, pe, ps, ae, op, we, st != 3'd0 && st != 3'd5, st == 3'd5, cnt};
  endfunction

  task automatic step(input string tag, input logic [21:0] v);
    q.push_back('{cyc, v, tag});
    @(posedge clk);
    #1;
  endtask
  task automatic idl(input string t, input logic [7:0] c); step(t, ev(0, 0, 0, 2'b00, 0, 0, 0, c)); endtask
  task automatic f(input logic [7:0] c); step("fetch", ev(1, 1, 1, 2'b01, 0, 0, 0, c)); endtask
  task automatic d(input string t, input logic pe, input logic [7:0] c);
    step(t, ev(2, 0, pe, pe ? 2'b10 : 2'b00, 0, 0, 0, c));
  endtask
  task automatic e(input string t, input logic [2:0] op, input logic we, input logic [7:0] c);
    step(t, ev(3, 0, 0, 2'b00, 0, op, we, c));
  endtask
  task automatic w(input string t, input logic [2:0] op, input logic [7:0] c);
    step(t, ev(4, 0, 0, 2'b00, 1, op, 0, c));
  endtask
  task automatic hlt(input string t, input logic [7:0] c); step(t, ev(5, 0, 0, 2'b00, 0, 0, 0, c)); endtask

  initial begin
    @(posedge clk); #1;
    idl("reset_hold", 0);
    rst = 0;
    idl("idle_no_start", 0);
    start = 1; instr = 8'h00;
    idl("idle_start", 0);
    start = 0;
    f(0); d("nop_dec", 0, 0);
    start = 1;
    f(1); d("nop_dec_start_held", 0, 1);
    start = 0; instr = 8'h25;
    f(2); d("lda_dec", 0, 2); e("lda_exec", 3'b000, 0, 2); w("lda_wb", 3'b000, 2);
    instr = 8'h61;
    f(3); d("add_dec", 0, 3); e("add_exec", 3'b001, 0, 3); w("add_wb", 3'b001, 3);
    instr = 8'h81;
    f(4); d("sub_dec", 0, 4); e("sub_exec", 3'b010, 0, 4); w("sub_wb", 3'b010, 4);
    instr = 8'h45;
    f(5); d("sta_dec", 0, 5); e("sta_exec", 3'b000, 1, 5);
    instr = 8'hA3;
    f(6); d("jmp_dec", 1, 6);
    instr = 8'hC7; zero = 0;
    f(7); zero = 1; d("jz_taken", 1, 7);
    f(8); zero = 0; d("jz_not_taken", 0, 8);
    instr = 8'h61;
    f(9); d("add_dec2", 0, 9);
    rst = 1;
    e("add_exec_rst", 3'b001, 0, 9);
    rst = 0;
    idl("after_rst_idle", 0);
    idl("after_rst_idle2", 0);
    start = 1; instr = 8'h00;
    idl("wrap_start", 0);
    start = 0;
    for (int i = 0; i < 256; i++) begin
      f(i[7:0]);
      d("wrap_nop", 0, i[7:0]);
    end
    instr = 8'hE0;
    f(0); d("hlt_dec", 0, 0);
    hlt("halt", 1);
    start = 1; zero = 1;
    hlt("halt_start", 1);
    start = 0;
    hlt("halt_hold", 1);
    rst = 1;
    hlt("halt_rst_edge", 1);
    rst = 0;
    idl("halt_rst_idle", 0);
    repeat (2) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
